// File: rtl/int4_vec_packer.sv
// -----------------------------------------------------------------------------
// int4_vec_packer
//
// Producer side of the packed INT4 dot-product interface. Paired A/B beats of
// eight signed INT4 nibbles are assembled into VEC_W-bit lane vectors (66
// nibble lanes, payload in lanes LANE_OFF..LANE_OFF+31, every other lane zero)
// and handed to the MAC array over a valid/ready handshake.
//
// The block is double-buffered: an assembly buffer collects the next vector
// while the output register holds the previous one until it is consumed.
//
// Optional feature macro: INT4_PACK_CLAMP_EN
//   defined   : every input nibble 4'b1000 (-8) is replaced by 4'b1001 (-7) on
//               both A and B before packing (symmetric quantization range).
//   undefined : nibbles pass through unchanged; no clamp logic is built.
//
// Ports
//   clk       in   1     clock, all state updates on the rising edge
//   rst_n     in   1     asynchronous active-low reset
//   s_valid   in   1     input beat valid
//   s_ready   out  1     packer can accept a beat
//   s_a_data  in   32    8 INT4 A elements, element k in bits [4k+3:4k]
//   s_b_data  in   32    8 INT4 B elements, same layout
//   s_last    in   1     final beat of the current vector (rest zero-padded)
//   m_valid   out  1     output vector valid
//   m_ready   in   1     consumer accepts the vector
//   m_a_vec   out  264   packed A vector
//   m_b_vec   out  264   packed B vector
//   m_count   out  6     number of valid elements in the output vector (1..32)
// -----------------------------------------------------------------------------
module int4_vec_packer #(
    parameter int BEATS    = 4,
    parameter int LANE_OFF = 2,
    parameter int VEC_W    = 264
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_a_data,
    input  logic [31:0]      s_b_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [VEC_W-1:0] m_a_vec,
    output logic [VEC_W-1:0] m_b_vec,
    output logic [5:0]       m_count
);

    localparam int BEAT_W = 32;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // Optional -8 -> -7 substitution applied nibble by nibble to one beat word.
    function automatic logic [BEAT_W-1:0] clamp_word(input logic [BEAT_W-1:0] w);
        logic [BEAT_W-1:0] r;
        r = w;
`ifdef INT4_PACK_CLAMP_EN
        for (int k = 0; k < BEAT_W / 4; k++) begin
            if (w[4*k +: 4] == 4'b1000) begin
                r[4*k +: 4] = 4'b1001;
            end else begin
                r[4*k +: 4] = w[4*k +: 4];
            end
        end
`endif
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic             init_q,     init_d;      // first edge after reset seen
    logic [CNT_W-1:0] cnt_q,      cnt_d;       // beats in the open assembly
    logic [VEC_W-1:0] asm_a_q,    asm_a_d;
    logic [VEC_W-1:0] asm_b_q,    asm_b_d;
    logic             asm_done_q, asm_done_d;  // completed assembly waiting
    logic [5:0]       asm_cnt_q,  asm_cnt_d;   // element count of held assembly
    logic             m_valid_q,  m_valid_d;
    logic [VEC_W-1:0] m_a_q,      m_a_d;
    logic [VEC_W-1:0] m_b_q,      m_b_d;
    logic [5:0]       m_count_q,  m_count_d;

    // ---------------------------------------------------------------------
    // Combinational helpers
    // ---------------------------------------------------------------------
    logic             out_free_s;
    logic             beat_acc_s;
    logic             beat_last_s;
    logic [CNT_W-1:0] base_cnt_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic [VEC_W-1:0] base_a_s;
    logic [VEC_W-1:0] base_b_s;
    logic [VEC_W-1:0] wr_a_s;
    logic [VEC_W-1:0] wr_b_s;
    logic [5:0]       elem_cnt_s;

    // Only stall input when a finished vector is stuck behind an unconsumed one.
    assign s_ready    = init_q && !(asm_done_q && m_valid_q && !m_ready);
    assign out_free_s = !m_valid_q || m_ready;
    assign beat_acc_s = s_valid && s_ready;

    assign m_valid = m_valid_q;
    assign m_a_vec = m_a_q;
    assign m_b_vec = m_b_q;
    assign m_count = m_count_q;

    // Assembly view a new beat lands in: a held (completed) assembly leaves for
    // the output this same cycle whenever a beat can be accepted, so the beat
    // starts a fresh, zeroed buffer at beat index 0.
    always_comb begin
        base_a_s   = asm_a_q;
        base_b_s   = asm_b_q;
        base_cnt_s = cnt_q;
        if (asm_done_q) begin
            base_a_s   = '0;
            base_b_s   = '0;
            base_cnt_s = '0;
        end else begin
            base_a_s   = asm_a_q;
            base_b_s   = asm_b_q;
            base_cnt_s = cnt_q;
        end
    end

    // Merge the incoming beat into its eight nibble lanes.
    always_comb begin
        wr_a_s      = base_a_s;
        wr_b_s      = base_b_s;
        beat_last_s = 1'b0;
        elem_cnt_s  = 6'(8 * (int'(base_cnt_s) + 1));
        cnt_next_s  = base_cnt_s;
        if (beat_acc_s) begin
            wr_a_s[4*LANE_OFF + BEAT_W*int'(base_cnt_s) +: BEAT_W] = clamp_word(s_a_data);
            wr_b_s[4*LANE_OFF + BEAT_W*int'(base_cnt_s) +: BEAT_W] = clamp_word(s_b_data);
            beat_last_s = (base_cnt_s == LAST_BEAT) || s_last;
            cnt_next_s  = base_cnt_s + CNT_W'(1);
        end else begin
            wr_a_s      = base_a_s;
            wr_b_s      = base_b_s;
            beat_last_s = 1'b0;
            cnt_next_s  = base_cnt_s;
        end
    end

    // Next-state: move completed assemblies to the output, or hold them.
    always_comb begin
        init_d     = 1'b1;
        cnt_d      = cnt_q;
        asm_a_d    = asm_a_q;
        asm_b_d    = asm_b_q;
        asm_done_d = asm_done_q;
        asm_cnt_d  = asm_cnt_q;
        // Output drops only on a handshake; loads below override this.
        m_valid_d  = m_valid_q && !m_ready;
        m_a_d      = m_a_q;
        m_b_d      = m_b_q;
        m_count_d  = m_count_q;

        if (asm_done_q && out_free_s) begin
            // Held vector goes out; any accepted beat opens the next assembly.
            m_valid_d = 1'b1;
            m_a_d     = asm_a_q;
            m_b_d     = asm_b_q;
            m_count_d = asm_cnt_q;
            asm_a_d   = wr_a_s;
            asm_b_d   = wr_b_s;
            if (beat_last_s) begin
                asm_done_d = 1'b1;
                asm_cnt_d  = elem_cnt_s;
                cnt_d      = '0;
            end else begin
                asm_done_d = 1'b0;
                asm_cnt_d  = 6'd0;
                cnt_d      = cnt_next_s;
            end
        end else if (asm_done_q) begin
            // Output still occupied: keep everything, input is stalled.
            asm_done_d = 1'b1;
        end else if (beat_last_s && out_free_s) begin
            // Completing beat goes straight to the output register.
            m_valid_d  = 1'b1;
            m_a_d      = wr_a_s;
            m_b_d      = wr_b_s;
            m_count_d  = elem_cnt_s;
            asm_a_d    = '0;
            asm_b_d    = '0;
            asm_done_d = 1'b0;
            asm_cnt_d  = 6'd0;
            cnt_d      = '0;
        end else if (beat_last_s) begin
            // Completed but the output is busy: park it in the assembly buffer.
            asm_a_d    = wr_a_s;
            asm_b_d    = wr_b_s;
            asm_done_d = 1'b1;
            asm_cnt_d  = elem_cnt_s;
            cnt_d      = '0;
        end else begin
            // Ordinary beat (or idle): keep filling the open assembly.
            asm_a_d    = wr_a_s;
            asm_b_d    = wr_b_s;
            asm_done_d = 1'b0;
            cnt_d      = cnt_next_s;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q     <= 1'b0;
            cnt_q      <= '0;
            asm_a_q    <= '0;
            asm_b_q    <= '0;
            asm_done_q <= 1'b0;
            asm_cnt_q  <= 6'd0;
            m_valid_q  <= 1'b0;
            m_a_q      <= '0;
            m_b_q      <= '0;
            m_count_q  <= 6'd0;
        end else begin
            init_q     <= init_d;
            cnt_q      <= cnt_d;
            asm_a_q    <= asm_a_d;
            asm_b_q    <= asm_b_d;
            asm_done_q <= asm_done_d;
            asm_cnt_q  <= asm_cnt_d;
            m_valid_q  <= m_valid_d;
            m_a_q      <= m_a_d;
            m_b_q      <= m_b_d;
            m_count_q  <= m_count_d;
        end
    end

endmodule

// File: tb/tb_int4_vec_packer.sv
// -----------------------------------------------------------------------------
// tb_int4_vec_packer
//
// Directed self-checking bench for int4_vec_packer. Inputs change 1 ns after
// the rising edge and outputs are sampled at that same point, well away from
// the active edge. Expected vectors are built from the hand-chosen beat words.
// -----------------------------------------------------------------------------
module tb_int4_vec_packer;

    logic         clk;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_a_data;
    logic [31:0]  s_b_data;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [263:0] m_a_vec;
    logic [263:0] m_b_vec;
    logic [5:0]   m_count;

    int n_chk;
    int n_bad;

    int4_vec_packer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_a_data (s_a_data),
        .s_b_data (s_b_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_a_vec  (m_a_vec),
        .m_b_vec  (m_b_vec),
        .m_count  (m_count)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [263:0] obs, input logic [263:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lane vector with beat words w0..w3 in lanes 2..33, all else zero.
    function automatic logic [263:0] mk_vec(input logic [31:0] w0, input logic [31:0] w1,
                                            input logic [31:0] w2, input logic [31:0] w3);
        return {128'd0, w3, w2, w1, w0, 8'd0};
    endfunction

    // Present one beat for exactly one edge, then sample 1 ns later.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
        s_valid  = 1'b1;
        s_a_data = a;
        s_b_data = b;
        s_last   = last;
        @(posedge clk);
        #1;
        s_valid  = 1'b0;
        s_last   = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

`ifdef INT4_PACK_CLAMP_EN
    localparam logic [31:0] CLAMP_A = 32'h99999999;
    localparam logic [31:0] CLAMP_B = 32'h90909090;
`else
    localparam logic [31:0] CLAMP_A = 32'h88888888;
    localparam logic [31:0] CLAMP_B = 32'h80808080;
`endif

    logic [263:0] v1_a;
    logic [263:0] v2_a;
    logic [31:0]  wa;

    initial begin
        n_chk    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_a_data = 32'd0;
        s_b_data = 32'd0;
        s_last   = 1'b0;
        m_ready  = 1'b1;

        // ---------------- reset values ----------------
        #2;
        check("rst_m_valid", {263'd0, m_valid}, 264'd0);
        check("rst_s_ready", {263'd0, s_ready}, 264'd0);
        check("rst_m_a_vec", m_a_vec, 264'd0);
        check("rst_m_count", {258'd0, m_count}, 264'd0);
        #10;
        rst_n = 1'b1;
        #1;
        check("rst_ready_before_edge", {263'd0, s_ready}, 264'd0);
        idle_cycle();
        check("ready_after_edge", {263'd0, s_ready}, 264'd1);

        // ---------------- full vector, m_ready=1 ----------------
        send(32'h76543210, 32'h11111111, 1'b0);
        send(32'hFEDCBA98, 32'h11111111, 1'b0);
        send(32'h11111111, 32'h11111111, 1'b0);
        check("full_no_valid_early", {263'd0, m_valid}, 264'd0);
        send(32'h22222222, 32'h11111111, 1'b0);
        check("full_valid", {263'd0, m_valid}, 264'd1);
        check("full_a_lo", {232'd0, m_a_vec[39:8]}, {232'd0, 32'h76543210});
        check("full_a_hi", {232'd0, m_a_vec[135:104]}, {232'd0, 32'h22222222});
        check("full_a_vec", m_a_vec, mk_vec(32'h76543210, 32'hFEDCBA98, 32'h11111111, 32'h22222222));
        check("full_b_vec", m_b_vec, mk_vec(32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111));
        check("full_count", {258'd0, m_count}, 264'd32);
        idle_cycle();
        check("full_valid_drop", {263'd0, m_valid}, 264'd0);

        // ---------------- s_last on beat 1, then s_last on beat 0 ----------------
        send(32'hAAAAAAAA, 32'h00000000, 1'b0);
        send(32'h55555555, 32'h00000000, 1'b1);
        check("last1_valid", {263'd0, m_valid}, 264'd1);
        check("last1_a_vec", m_a_vec, {192'd0, 64'h55555555AAAAAAAA, 8'd0});
        check("last1_count", {258'd0, m_count}, 264'd16);
        send(32'h12345678, 32'h9ABCDEF0, 1'b1);
        check("last0_valid", {263'd0, m_valid}, 264'd1);
        check("last0_a_vec", m_a_vec, mk_vec(32'h12345678, 32'd0, 32'd0, 32'd0));
        check("last0_b_vec", m_b_vec, mk_vec(32'h9ABCDEF0, 32'd0, 32'd0, 32'd0));
        check("last0_count", {258'd0, m_count}, 264'd8);
        idle_cycle();

        // ---------------- backpressure: m_ready=0 for 10 cycles ----------------
        m_ready = 1'b0;
        v1_a = mk_vec(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F01);
        v2_a = mk_vec(32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'hD1D2D3D4);
        send(32'h01020304, 32'h0, 1'b0);
        send(32'h05060708, 32'h0, 1'b0);
        send(32'h090A0B0C, 32'h0, 1'b0);
        send(32'h0D0E0F01, 32'h0, 1'b0);
        check("bp_v1_valid", {263'd0, m_valid}, 264'd1);
        check("bp_ready_b0", {263'd0, s_ready}, 264'd1);
        send(32'hA1A2A3A4, 32'h1, 1'b0);
        check("bp_ready_b1", {263'd0, s_ready}, 264'd1);
        send(32'hB1B2B3B4, 32'h1, 1'b0);
        send(32'hC1C2C3C4, 32'h1, 1'b0);
        check("bp_ready_b3", {263'd0, s_ready}, 264'd1);
        send(32'hD1D2D3D4, 32'h1, 1'b0);
        check("bp_stall", {263'd0, s_ready}, 264'd0);
        check("bp_hold_a", m_a_vec, v1_a);
        idle_cycle();
        idle_cycle();
        check("bp_hold_valid", {263'd0, m_valid}, 264'd1);
        check("bp_hold_a2", m_a_vec, v1_a);
        check("bp_hold_cnt", {258'd0, m_count}, 264'd32);
        m_ready = 1'b1;
        #1;
        check("bp_ready_release", {263'd0, s_ready}, 264'd1);
        @(posedge clk);
        #1;
        check("bp_v2_valid", {263'd0, m_valid}, 264'd1);
        check("bp_v2_a", m_a_vec, v2_a);
        check("bp_v2_b", m_b_vec, mk_vec(32'h1, 32'h1, 32'h1, 32'h1));
        idle_cycle();
        check("bp_v2_drop", {263'd0, m_valid}, 264'd0);

        // ---------------- back-to-back full vectors ----------------
        for (int v = 0; v < 3; v++) begin
            for (int j = 0; j < 4; j++) begin
                wa = 32'h01010101 * (4 * v + j + 1);
                send(wa, ~wa, 1'b0);
                check("b2b_ready", {263'd0, s_ready}, 264'd1);
                check("b2b_valid", {263'd0, m_valid}, {263'd0, (j == 3)});
            end
            check("b2b_a_vec", m_a_vec,
                  mk_vec(32'h01010101 * (4 * v + 1), 32'h01010101 * (4 * v + 2),
                         32'h01010101 * (4 * v + 3), 32'h01010101 * (4 * v + 4)));
            check("b2b_b_vec", m_b_vec,
                  mk_vec(~(32'h01010101 * (4 * v + 1)), ~(32'h01010101 * (4 * v + 2)),
                         ~(32'h01010101 * (4 * v + 3)), ~(32'h01010101 * (4 * v + 4))));
        end
        idle_cycle();

        // ---------------- reset mid-vector ----------------
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        rst_n = 1'b0;
        #2;
        check("mid_rst_valid", {263'd0, m_valid}, 264'd0);
        check("mid_rst_a", m_a_vec, 264'd0);
        rst_n = 1'b1;
        idle_cycle();
        check("mid_rst_ready", {263'd0, s_ready}, 264'd1);
        send(32'h13579BDF, 32'h02468ACE, 1'b0);
        send(32'h0000000F, 32'h0, 1'b0);
        check("mid_rst_no_emit", {263'd0, m_valid}, 264'd0);
        send(32'h00000000, 32'h0, 1'b0);
        send(32'hF0000000, 32'h0, 1'b0);
        check("mid_rst_clean_valid", {263'd0, m_valid}, 264'd1);
        check("mid_rst_clean_a", m_a_vec, mk_vec(32'h13579BDF, 32'h0000000F, 32'h0, 32'hF0000000));
        check("mid_rst_clean_b", m_b_vec, mk_vec(32'h02468ACE, 32'h0, 32'h0, 32'h0));
        check("mid_rst_count", {258'd0, m_count}, 264'd32);
        idle_cycle();

        // ---------------- -8 nibbles (clamp feature) ----------------
        for (int j = 0; j < 4; j++) begin
            send(32'h88888888, 32'h80808080, 1'b0);
        end
        check("clamp_a", m_a_vec, mk_vec(CLAMP_A, CLAMP_A, CLAMP_A, CLAMP_A));
        check("clamp_b", m_b_vec, mk_vec(CLAMP_B, CLAMP_B, CLAMP_B, CLAMP_B));
        idle_cycle();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/int4_vec_packer.md
Name: int4_vec_packer

Overview:
- Producer side of the packed INT4 dot-product interface.
- Accepts a narrow stream of paired INT4 operand words, A and B, each beat carrying 8 nibbles.
- Assembles the words into 264-bit lane vectors: 66 nibble lanes, payload in lanes 2..33, all other lanes zero.
- Presents completed vectors to the MAC array with a valid/ready handshake. Double-buffered: the next vector is assembled while the previous one is held at the output.

Parameters:
- BEATS, 4, input beats per full vector (8 elements per beat, 32 elements total).
- LANE_OFF, 2, first payload nibble lane in the output vector.
- VEC_W, 264, output vector width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  input beat valid.
- s_ready  output  1  packer can accept a beat.
- s_a_data  input  32  8 signed INT4 A elements; element k in bits [4k+3:4k].
- s_b_data  input  32  8 signed INT4 B elements, same layout as s_a_data.
- s_last  input  1  final beat of the current vector; remaining lanes are zero-padded.
- m_valid  output  1  output vector valid.
- m_ready  input  1  consumer accepts the vector.
- m_a_vec  output  264  packed A vector.
- m_b_vec  output  264  packed B vector.
- m_count  output  6  number of valid elements in the output vector, 1..32.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: m_valid=0, m_a_vec=0, m_b_vec=0, m_count=0, s_ready=0 while in reset.
  - Internal state: beat counter=0, assembly buffers cleared.
  - s_ready goes to 1 on the first clock edge after rst_n deasserts.
- Beat accept: s_valid && s_ready at the rising edge.
  - Beat i (i = 0..BEATS-1) writes its 8 nibbles into lanes LANE_OFF+8i .. LANE_OFF+8i+7 of the A and B assembly buffers.
  - The beat counter increments.
- Vector completion: the accepted beat has i = BEATS-1, or s_last=1.
  - Lanes not yet written are zero. Lanes 0..1 and 34..65 are always zero.
  - Element count = 8*(i+1).
  - The assembly buffer moves to the output register on the same edge when the output is empty or being consumed (m_valid && m_ready) that cycle.
  - Otherwise the completed assembly is held. s_ready=0 until the output register frees.
  - The beat counter resets to 0 when the assembly moves to the output register.
  - Assembly buffers are cleared to zero once they transfer.
- Latency: m_valid asserts 1 cycle after the completing beat is accepted when the output is free.
  - Full rate: 1 vector per BEATS cycles with m_ready held high.
- Output hold: m_a_vec, m_b_vec and m_count are stable while m_valid && !m_ready. m_valid drops only after a handshake.
- s_ready = !(assembly complete && output occupied && !m_ready). It is combinational from registered state and m_ready.
- Simultaneous events:
  - Output handshake plus a completing beat in the same cycle: the new vector loads and m_valid stays 1 with no bubble.
  - s_last on beat 0: a vector with m_count=8 is emitted.
- Reset mid-vector: partial assembly is discarded and no vector is emitted.
- Data is opaque apart from the optional clamp. Sign is preserved by nibble placement only; there is no extension.

Optional Feature:
- Macro INT4_PACK_CLAMP_EN.
- When defined: every input nibble equal to 4'b1000 (-8) is replaced by 4'b1001 (-7) on both A and B before packing. This gives a symmetric quantization range.
- When undefined: nibbles pass unchanged and there is no extra logic.

Test Plan:
- Reset then 4 beats, A words 0x76543210, 0xFEDCBA98, 0x11111111, 0x22222222, B all 0x11111111, m_ready=1:
  - m_valid=1 one cycle after beat 3.
  - m_a_vec[39:8]=0x76543210, m_a_vec[135:104]=0x22222222; bits [7:0] and [263:136] are 0.
  - m_count=32.
- s_last on beat 1 (A 0xAAAAAAAA, 0x55555555): m_a_vec[71:8]=0x55555555AAAAAAAA, rest 0, m_count=16. The next vector starts at lane 2.
- m_ready=0 held for 10 cycles with continuous input:
  - The second vector assembles, then s_ready=0.
  - The first vector is held stable.
  - Releasing m_ready transfers the second vector with no beat loss.
- Back-to-back full vectors with m_ready=1: m_valid asserts every 4 cycles and s_ready stays 1 throughout.
- rst_n pulsed low after 2 beats: m_valid stays 0. The next 4 beats form a clean vector with no stale lanes.
- A=0x88888888 ×4:
  - With INT4_PACK_CLAMP_EN, payload lanes read 0x9.
  - Without INT4_PACK_CLAMP_EN, payload lanes read 0x8.
